rc4_xor_unit: RTL and testbench

RC4_XOR_UNIT -- requirements
Module: rc4_xor_unit

---
 rtl/rc4_xor_unit_if.sv | 27 ++
 rtl/rc4_xor_unit.sv | 128 ++++++++++++
 tb/tb_rc4_xor_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_xor_unit_if.sv
// Handshake bundle between the rc4 keystream core, the data source/sink and rc4_xor_unit.
// slave is the unit's view, master is the environment's view.
interface rc4_xor_unit_if;
   logic        start;
   logic [15:0] msg_len;
   logic        cipher_req;
   logic        cipher_valid;
   logic [7:0]  keystream;
   logic        din_valid;
   logic [7:0]  din;
   logic        din_ready;
   logic        dout_valid;
   logic [7:0]  dout;
   logic        dout_ready;
   logic        busy;
   logic        done;

   modport slave (
      input  start, msg_len, cipher_valid, keystream, din_valid, din, dout_ready,
      output cipher_req, din_ready, dout_valid, dout, busy, done
   );

   modport master (
      output start, msg_len, cipher_valid, keystream, din_valid, din, dout_ready,
      input  cipher_req, din_ready, dout_valid, dout, busy, done
   );
endinterface

// File: rtl/rc4_xor_unit.sv
// XORs a byte stream with an rc4 keystream prefetched into a small FIFO;
// one output register stage with valid/ready backpressure.
module rc4_xor_unit #(
   parameter int FIFO_DEPTH = 4
) (
   input logic          clk,
   input logic          rst_n,
   rc4_xor_unit_if.slave bus
);
   localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t        state;
   logic [15:0]   len_q;
   logic [15:0]   fetch_cnt;
   logic [15:0]   in_cnt;
   logic [15:0]   out_cnt;
   logic [7:0]    ks_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   fill;
   logic [7:0]    dout_p1;
   logic          vld_p1;
   logic          done_q;

   logic          cipher_req;
   logic          din_ready;
   logic          push;
   logic          pop;
   logic          out_acc;

   // Handshake qualifiers depend only on registered state plus dout_ready.
   assign cipher_req = (state == RUN) && (fill != FULL_CNT) && (fetch_cnt < len_q);
   assign din_ready  = (state == RUN) && (fill != '0) && (in_cnt < len_q) &&
                       (!vld_p1 || bus.dout_ready);
   assign push       = cipher_req && bus.cipher_valid;
   assign pop        = din_ready && bus.din_valid;
   assign out_acc    = vld_p1 && bus.dout_ready;

   assign bus.cipher_req = cipher_req;
   assign bus.din_ready  = din_ready;
   assign bus.dout_valid = vld_p1;
   assign bus.dout       = dout_p1;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = done_q;

   // Keystream storage: data only, pointers/fill define what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         ks_mem[wr_ptr] <= bus.keystream;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         len_q     <= '0;
         fetch_cnt <= '0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fill      <= '0;
         dout_p1   <= '0;
         vld_p1    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.msg_len != 16'd0) begin
                     len_q     <= bus.msg_len;
                     fetch_cnt <= '0;
                     in_cnt    <= '0;
                     out_cnt   <= '0;
                     wr_ptr    <= '0;
                     rd_ptr    <= '0;
                     fill      <= '0;
                     vld_p1    <= 1'b0;
                     state     <= RUN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end

            RUN: begin
               if (push) begin
                  wr_ptr    <= wr_ptr + PW'(1);
                  fetch_cnt <= fetch_cnt + 16'd1;
               end
               // stage p1: XOR result registered, FIFO head consumed
               if (pop) begin
                  rd_ptr  <= rd_ptr + PW'(1);
                  in_cnt  <= in_cnt + 16'd1;
                  dout_p1 <= bus.din ^ ks_mem[rd_ptr];
                  vld_p1  <= 1'b1;
               end else if (out_acc) begin
                  vld_p1 <= 1'b0;
               end
               if (push && !pop) begin
                  fill <= fill + (PW+1)'(1);
               end else if (pop && !push) begin
                  fill <= fill - (PW+1)'(1);
               end
               if (out_acc) begin
                  out_cnt <= out_cnt + 16'd1;
                  if (out_cnt == len_q - 16'd1) begin
                     state  <= FIN;
                     done_q <= 1'b1;
                  end
               end
            end

            FIN: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rc4_xor_unit.sv
// Scoreboard bench for rc4_xor_unit: bench-side keystream FIFO model predicts
// every output byte; handshake rules are checked on each sampled cycle.
module tb_rc4_xor_unit;
   logic clk;
   logic rst_n;

   rc4_xor_unit_if bus ();

   rc4_xor_unit #(.FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_pass;

   logic [7:0] ks_tab  [64];
   logic [7:0] din_tab [64];
   int         ks_i;
   int         din_i;
   logic [7:0] ks_model[$];
   logic [7:0] exp_q[$];

   int cv_mode;
   int dv_mode;
   int dr_mode;
   int ks_xfers;
   int done_cnt;
   int out_accs;

   bit         hold_prev;
   logic [7:0] dout_prev;
   bit         expect_vld;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic mode_bit(input int mode);
      if (mode == 1) return 1'b1;
      if (mode == 2) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   task automatic fill_tabs(input bit rnd);
      for (int i = 0; i < 64; i++) begin
         ks_tab[i]  = rnd ? 8'($urandom) : 8'(i * 7 + 3);
         din_tab[i] = rnd ? 8'($urandom) : 8'(i * 13 + 5);
      end
      ks_i  = 0;
      din_i = 0;
   endtask

   task automatic clear_model();
      ks_model.delete();
      exp_q.delete();
      hold_prev  = 1'b0;
      expect_vld = 1'b0;
   endtask

   // One clock: drive at negedge, sample handshakes just after.
   task automatic step();
      logic [7:0] ks_b;
      @(negedge clk);
      bus.cipher_valid = mode_bit(cv_mode);
      bus.keystream    = ks_tab[ks_i & 63];
      bus.din_valid    = mode_bit(dv_mode);
      bus.din          = din_tab[din_i & 63];
      bus.dout_ready   = mode_bit(dr_mode);
      #1;
      if (expect_vld) chk("dout_latency", bus.dout_valid, 1'b1);
      if (hold_prev) begin
         chk("hold_valid", bus.dout_valid, 1'b1);
         chk("hold_data", bus.dout, dout_prev);
      end
      if (bus.dout_valid && bus.dout_ready) begin
         chk("sb_has_entry", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) chk("dout", bus.dout, exp_q.pop_front());
         out_accs++;
      end
      if (bus.cipher_req && bus.cipher_valid) begin
         ks_model.push_back(bus.keystream);
         ks_i++;
         ks_xfers++;
      end
      expect_vld = 1'b0;
      if (bus.din_ready && bus.din_valid) begin
         chk("ks_available", ks_model.size() != 0, 1'b1);
         ks_b = (ks_model.size() != 0) ? ks_model.pop_front() : 8'h00;
         exp_q.push_back(bus.din ^ ks_b);
         din_i++;
         expect_vld = 1'b1;
      end
      hold_prev = bus.dout_valid && !bus.dout_ready;
      dout_prev = bus.dout;
      if (bus.done) done_cnt++;
   endtask

   task automatic start_msg(input logic [15:0] len);
      bus.start   = 1'b1;
      bus.msg_len = len;
      step();
      bus.start   = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         step();
         n++;
      end
      chk("done_pulses", done_cnt - d0, 1);
      chk("sb_drained", exp_q.size(), 0);
      chk("ks_model_empty", ks_model.size(), 0);
      step();
      chk("done_one_cycle", bus.done, 1'b0);
      chk("idle_busy", bus.busy, 1'b0);
   endtask

   initial begin
      int x0;
      int d0;
      int n;
      n_chk = 0; n_pass = 0;
      ks_xfers = 0; done_cnt = 0; out_accs = 0;
      cv_mode = 0; dv_mode = 0; dr_mode = 0;
      bus.start = 1'b0; bus.msg_len = '0; bus.cipher_valid = 1'b0; bus.keystream = '0;
      bus.din_valid = 1'b0; bus.din = '0; bus.dout_ready = 1'b0;
      clear_model();
      fill_tabs(1'b0);
      rst_n = 1'b0;
      #12;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_cipher_req", bus.cipher_req, 1'b0);
      chk("rst_din_ready", bus.din_ready, 1'b0);
      chk("rst_dout_valid", bus.dout_valid, 1'b0);
      chk("rst_dout", bus.dout, 8'h00);
      chk("rst_done", bus.done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed three-byte message
      fill_tabs(1'b0);
      ks_tab[0] = 8'h11; ks_tab[1] = 8'h22; ks_tab[2] = 8'h33;
      din_tab[0] = 8'hA0; din_tab[1] = 8'hB0; din_tab[2] = 8'hC0;
      cv_mode = 1; dv_mode = 1; dr_mode = 1;
      x0 = ks_xfers;
      start_msg(16'd3);
      run_to_done(40);
      chk("three_ks_xfers", ks_xfers - x0, 3);

      // FIFO fills to depth with no data consumed
      fill_tabs(1'b1);
      cv_mode = 1; dv_mode = 0; dr_mode = 1;
      x0 = ks_xfers;
      start_msg(16'd8);
      for (int i = 0; i < 10; i++) step();
      chk("full_ks_xfers", ks_xfers - x0, 4);
      chk("full_cipher_req", bus.cipher_req, 1'b0);
      chk("full_din_ready", bus.din_ready, 1'b1);
      chk("full_busy", bus.busy, 1'b1);
      dv_mode = 1;
      run_to_done(60);
      chk("len8_ks_xfers", ks_xfers - x0, 8);

      // Output backpressure
      fill_tabs(1'b1);
      cv_mode = 1; dv_mode = 1; dr_mode = 0;
      start_msg(16'd4);
      n = 0;
      while (!bus.dout_valid && n < 20) begin
         step();
         n++;
      end
      chk("first_dout_seen", bus.dout_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_din_ready", bus.din_ready, 1'b0);
      end
      dr_mode = 1;
      run_to_done(60);

      // Zero-length message
      cv_mode = 1; dv_mode = 1; dr_mode = 1;
      d0 = done_cnt;
      start_msg(16'd0);
      chk("zero_done", bus.done, 1'b1);
      chk("zero_busy", bus.busy, 1'b0);
      chk("zero_cipher_req", bus.cipher_req, 1'b0);
      step();
      chk("zero_done_once", done_cnt - d0, 1);
      chk("zero_busy_after", bus.busy, 1'b0);

      // Abort mid-message by reset, then a fresh message
      fill_tabs(1'b1);
      start_msg(16'd5);
      x0 = out_accs;
      n = 0;
      while (out_accs - x0 < 2 && n < 30) begin
         step();
         n++;
      end
      chk("abort_two_out", out_accs - x0, 2);
      d0 = done_cnt;
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_cipher_req", bus.cipher_req, 1'b0);
      chk("abort_din_ready", bus.din_ready, 1'b0);
      chk("abort_dout_valid", bus.dout_valid, 1'b0);
      chk("abort_dout", bus.dout, 8'h00);
      chk("abort_done", bus.done, 1'b0);
      clear_model();
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("abort_no_done", done_cnt - d0, 0);
      fill_tabs(1'b1);
      start_msg(16'd2);
      run_to_done(40);

      // Random handshakes, longer message, start ignored while busy
      fill_tabs(1'b1);
      cv_mode = 2; dv_mode = 2; dr_mode = 2;
      x0 = ks_xfers;
      start_msg(16'd20);
      for (int i = 0; i < 5; i++) step();
      start_msg(16'd3);
      run_to_done(400);
      chk("rand_ks_xfers", ks_xfers - x0, 20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
